servo_motion_sched: RTL and testbench
=====================================

// Module: servo_motion_sched
// PURPOSE
//  Motion scheduler that drives the l_ctrl/r_ctrl inputs of the servo PWM block.
//  Arbitrates three position sources, highest priority first:
//    manual buttons -> host position command (valid/ready) -> automatic ping-pong sweep.
//  Keeps a step-exact mirror of the servo position by running the servo's
//  SLOW_TICK_MAX update tick in lockstep from the same reset.
// PARAMETERS
//  SLOW_TICK_MAX  5000000  clocks per servo update tick; must equal the servo's value
//  POS_MAX        40       steps from 0 deg to 180 deg ((PULSE_180-PULSE_0)/STEP_SIZE)
//  POS_W          6        width of position/command fields; must satisfy 2**POS_W > POS_MAX
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  btn_l      in   1      manual left request, debounced level
//  btn_r      in   1      manual right request, debounced level
//  sweep_en   in   1      enable automatic 0<->POS_MAX sweep while idle
//  cmd_valid  in   1      host target command valid
//  cmd_pos    in   POS_W  host target position in steps
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
//  cmd_done   out  1      1-cycle pulse: accepted target reached
//  cmd_abort  out  1      1-cycle pulse: accepted target cancelled by manual input
//  l_ctrl     out  1      to servo: move one step left at next tick
//  r_ctrl     out  1      to servo: move one step right at next tick
//  pos        out  POS_W  mirrored servo position, 0..POS_MAX
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset values: pos=0, l_ctrl=r_ctrl=0, cmd_done=cmd_abort=0, state=IDLE, tick counter=0.
//    cmd_ready is 1 out of reset (IDLE), subject to the manual-button rule below.
//  - Tick: counter 0..SLOW_TICK_MAX-1; tick=1 when counter==SLOW_TICK_MAX-1.
//    Both blocks share rst, so tick is phase-aligned with the servo's update cycle.
//  - On a tick cycle, in this order:
//    - Update pos from the current l_ctrl/r_ctrl, exactly as the servo does:
//      - r_ctrl has priority over l_ctrl.
//      - pos saturates at POS_MAX and at 0.
//    - Compute the next l_ctrl/r_ctrl and the next state from the updated pos.
//  - l_ctrl/r_ctrl are registered and change only on tick cycles, so the servo samples
//    a stable level. Never both 1.
//  - FSM states: IDLE, MANUAL, SEEK, SWEEP_UP, SWEEP_DN. Transitions are evaluated on tick
//    cycles, except command acceptance.
//    - IDLE:
//      - btn_l^btn_r -> MANUAL.
//      - Else a pending accepted command -> SEEK.
//      - Else sweep_en -> SWEEP_UP if pos<POS_MAX, otherwise SWEEP_DN.
//      - Outputs 0.
//    - MANUAL:
//      - r_ctrl=btn_r&~btn_l; l_ctrl=btn_l&~btn_r.
//      - Both or neither pressed -> IDLE with outputs 0.
//    - SEEK:
//      - r_ctrl=(pos<tgt); l_ctrl=(pos>tgt).
//      - When pos==tgt after the update: cmd_done pulse, -> IDLE.
//      - A manual press (btn_l^btn_r) in SEEK -> MANUAL, cmd_abort pulse, target discarded.
//    - SWEEP_UP: r_ctrl=1; pos==POS_MAX -> SWEEP_DN.
//    - SWEEP_DN: l_ctrl=1; pos==0 -> SWEEP_UP.
//    - Sweep exits:
//      - sweep_en=0 -> IDLE.
//      - Pending command or manual press -> IDLE for one tick, then arbitrate.
//  - Command acceptance (any cycle):
//    - cmd_ready = ~cmd_pend & ~(btn_l|btn_r) & state!=SEEK.
//    - On accept: tgt = min(cmd_pos, POS_MAX); cmd_pend=1.
//    - cmd_pend is cleared on entry to SEEK.
//  - A command whose target equals pos on entry to SEEK:
//    - cmd_done on that tick cycle, outputs stay 0.
//  - cmd_done and cmd_abort are never asserted in the same cycle.
//  - Asynchronous rst mid-motion returns everything to reset values. Any pending or
//    in-flight command is dropped silently (no done, no abort).
// STRUCTURE
//  - Shared package servo_pkg:
//    - state encoding localparams.
//    - POS_MAX/POS_W defaults.
//    - SLOW_TICK_MAX, shared with servo.
//  - One natural sub-module: servo_tick_gen (tick counter and tick pulse). The servo can
//    later reuse the same sub-module, which guarantees alignment.
//  - Everything else is one FSM plus the pos/tgt registers.
// TESTING (SLOW_TICK_MAX=4, POS_MAX=5, POS_W=3; a servo instance in lockstep checks
//          target_pulse == PULSE_0 + pos*STEP_SIZE on every tick)
//  1. Reset, then cmd_pos=3 accepted
//     -> r_ctrl=1 for 3 ticks, pos 0->1->2->3, cmd_done at the 3rd tick, IDLE.
//  2. From pos=3, cmd_pos=7
//     -> clamped tgt=5, pos reaches 5, one cmd_done; cmd_ready=0 from accept to done.
//  3. SEEK to 5 from 0, btn_l at pos=2
//     -> cmd_abort pulse, MANUAL, pos decrements to 0 and holds there
//        (l_ctrl stays 1, saturated); release -> IDLE.
//  4. sweep_en=1 for 14 ticks
//     -> pos 0..5..0..; direction flips exactly at 5 and 0; never both ctrls high.
//  5. btn_l=btn_r=1 -> outputs 0, pos unchanged, cmd_ready=0 while either is held.
//  6. rst asserted mid-SEEK at pos=2
//     -> immediate pos=0, ctrls 0; after release no cmd_done/abort and tick phase restarts.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo motion scheduler and the servo PWM block:
// state encoding and default geometry / tick constants.
package servo_pkg;

  localparam int SLOW_TICK_MAX_DEF = 5000000;
  localparam int POS_MAX_DEF       = 40;
  localparam int POS_W_DEF         = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MANUAL   = 3'd1,
    ST_SEEK     = 3'd2,
    ST_SWEEP_UP = 3'd3,
    ST_SWEEP_DN = 3'd4
  } state_t;

endpackage

// File: rtl/servo_motion_sched_if.sv
// Host/button/servo-side bundle of the motion scheduler; master = environment,
// slave = scheduler.
interface servo_motion_sched_if import servo_pkg::*; #(
  parameter int POS_W = POS_W_DEF
);
  logic             btn_l;
  logic             btn_r;
  logic             sweep_en;
  logic             cmd_valid;
  logic [POS_W-1:0] cmd_pos;
  logic             cmd_ready;
  logic             cmd_done;
  logic             cmd_abort;
  logic             l_ctrl;
  logic             r_ctrl;
  logic [POS_W-1:0] pos;
  logic             busy;

  modport master (
    output btn_l, btn_r, sweep_en, cmd_valid, cmd_pos,
    input  cmd_ready, cmd_done, cmd_abort, l_ctrl, r_ctrl, pos, busy
  );

  modport slave (
    input  btn_l, btn_r, sweep_en, cmd_valid, cmd_pos,
    output cmd_ready, cmd_done, cmd_abort, l_ctrl, r_ctrl, pos, busy
  );
endinterface

// File: rtl/servo_tick_gen.sv
// Free-running update-tick generator; the servo and the scheduler both use it
// from the same reset, so their ticks stay phase-aligned.
module servo_tick_gen import servo_pkg::*; #(
  parameter int TICK_MAX = SLOW_TICK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/servo_motion_sched.sv
// Motion scheduler: arbitrates manual buttons, host commands and a ping-pong
// sweep into l_ctrl/r_ctrl, and mirrors the servo position step-exactly.
module servo_motion_sched import servo_pkg::*; #(
  parameter int SLOW_TICK_MAX = SLOW_TICK_MAX_DEF,
  parameter int POS_MAX       = POS_MAX_DEF,
  parameter int POS_W         = POS_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  servo_motion_sched_if.slave bus
);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);

  state_t           state, state_nx;
  logic [POS_W-1:0] pos, pos_upd, tgt;
  logic             pend, seek_entry;
  logic             l_ctrl, r_ctrl, l_nx, r_nx;
  logic             done, abort, done_nx, abort_nx;
  logic             tick, manual, ready, accept;
  logic             btn_l, btn_r;

  servo_tick_gen #(.TICK_MAX(SLOW_TICK_MAX)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign btn_l  = bus.btn_l;
  assign btn_r  = bus.btn_r;
  assign manual = btn_l ^ btn_r;
  assign ready  = ~pend & ~(btn_l | btn_r) & (state != ST_SEEK);
  assign accept = bus.cmd_valid & ready;

  // Same saturating update the servo applies at its tick: right wins over left.
  always_comb begin
    pos_upd = pos;
    if (r_ctrl) begin
      if (pos != PMAX) pos_upd = pos + 1'b1;
    end else if (l_ctrl) begin
      if (pos != '0) pos_upd = pos - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      l_ctrl    <= 1'b0;
      r_ctrl    <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nx;
      l_ctrl    <= l_nx;
      r_ctrl    <= r_nx;
      done      <= done_nx;
      abort     <= abort_nx;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_nx   = state;
    l_nx       = l_ctrl;
    r_nx       = r_ctrl;
    done_nx    = 1'b0;
    abort_nx   = 1'b0;
    seek_entry = 1'b0;
    if (tick) begin
      l_nx = 1'b0;
      r_nx = 1'b0;
      case (state)
        ST_IDLE: begin
          if (manual) begin
            state_nx = ST_MANUAL;
          end else if (pend) begin
            // A target already under the servo completes without ever moving.
            seek_entry = 1'b1;
            if (pos_upd == tgt) done_nx  = 1'b1;
            else                state_nx = ST_SEEK;
          end else if (bus.sweep_en) begin
            state_nx = (pos_upd < PMAX) ? ST_SWEEP_UP : ST_SWEEP_DN;
          end
        end
        ST_MANUAL: if (!manual) state_nx = ST_IDLE;
        ST_SEEK: begin
          if (pos_upd == tgt) begin
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else if (manual) begin
            abort_nx = 1'b1;
            state_nx = ST_MANUAL;
          end
        end
        ST_SWEEP_UP: begin
          if (!bus.sweep_en || pend || manual) state_nx = ST_IDLE;
          else if (pos_upd == PMAX)            state_nx = ST_SWEEP_DN;
        end
        ST_SWEEP_DN: begin
          if (!bus.sweep_en || pend || manual) state_nx = ST_IDLE;
          else if (pos_upd == '0)              state_nx = ST_SWEEP_UP;
        end
        default: state_nx = ST_IDLE;
      endcase

      // Drive levels for the next tick interval follow the state being entered.
      case (state_nx)
        ST_MANUAL: begin
          r_nx = btn_r & ~btn_l;
          l_nx = btn_l & ~btn_r;
        end
        ST_SEEK: begin
          r_nx = (pos_upd < tgt);
          l_nx = (pos_upd > tgt);
        end
        ST_SWEEP_UP: r_nx = 1'b1;
        ST_SWEEP_DN: l_nx = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pos <= '0;
    else if (tick) pos <= pos_upd;
  end

  // Accept and SEEK entry are mutually exclusive: one needs pend low, the other high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      tgt  <= '0;
    end else if (accept) begin
      pend <= 1'b1;
      tgt  <= (bus.cmd_pos > PMAX) ? PMAX : bus.cmd_pos;
    end else if (seek_entry) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    bus.cmd_ready = ready;
    bus.cmd_done  = done;
    bus.cmd_abort = abort;
    bus.l_ctrl    = l_ctrl;
    bus.r_ctrl    = r_ctrl;
    bus.pos       = pos;
    bus.busy      = (state != ST_IDLE);
  end
endmodule

// File: tb/tb_servo_motion_sched.sv
// Bench for servo_motion_sched: per-tick expectation table fed through a
// scoreboard queue, plus hand-written reset-mid-seek sequence.
module tb_servo_motion_sched;
  logic clk;
  logic rst;

  servo_motion_sched_if #(.POS_W(3)) bus ();

  servo_motion_sched #(
    .SLOW_TICK_MAX (4),
    .POS_MAX       (5),
    .POS_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cmd;
    logic       bl, br, sw, hv;
    logic [2:0] pos;
    logic       l, r, done, abort, busy, rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t mon_v;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pops     = 0;
  logic [1:0] ph;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side tick phase: the 4th edge after reset release is the first update.
  always @(posedge clk or posedge rst) begin
    if (rst) ph <= 2'd0;
    else     ph <= ph + 2'd1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int cmd, input bit bl, br, sw, hv, input int p,
                              input bit l, r, d, a, b, rdy);
    vec_t v;
    v.cmd = cmd; v.bl = bl; v.br = br; v.sw = sw; v.hv = hv;
    v.pos = 3'(p); v.l = l; v.r = r; v.done = d; v.abort = a; v.busy = b; v.rdy = rdy;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (ph == 2'd3) begin
        #1;
        if (sb.size() != 0) begin
          mon_v = sb.pop_front();
          check($sformatf("v%0d.pos", pops),   8'(bus.pos),       8'(mon_v.pos));
          check($sformatf("v%0d.l", pops),     8'(bus.l_ctrl),    8'(mon_v.l));
          check($sformatf("v%0d.r", pops),     8'(bus.r_ctrl),    8'(mon_v.r));
          check($sformatf("v%0d.done", pops),  8'(bus.cmd_done),  8'(mon_v.done));
          check($sformatf("v%0d.abort", pops), 8'(bus.cmd_abort), 8'(mon_v.abort));
          check($sformatf("v%0d.busy", pops),  8'(bus.busy),      8'(mon_v.busy));
          check($sformatf("v%0d.ready", pops), 8'(bus.cmd_ready), 8'(mon_v.rdy));
          pops++;
        end
      end else begin
        #1;
        check("gap.done",  8'(bus.cmd_done),  8'd0);
        check("gap.abort", 8'(bus.cmd_abort), 8'd0);
      end
    end
  end

  task automatic issue_cmd(input int cmd);
    bus.cmd_valid = 1'b1;
    bus.cmd_pos   = 3'(cmd);
    #1;
    check("cmd.ready_before", 8'(bus.cmd_ready), 8'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("cmd.ready_after", 8'(bus.cmd_ready), 8'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int  start;
    bit  seen;
    bus.btn_l     = v.bl;
    bus.btn_r     = v.br;
    bus.sweep_en  = v.sw;
    bus.cmd_valid = v.hv;
    bus.cmd_pos   = 3'd0;
    sb.push_back(v);
    start = pops;
    seen  = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk);
      #2;
      seen = (pops != start);
    end
    check("tick_seen", 8'(seen), 8'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.btn_l = 1'b0; bus.btn_r = 1'b0; bus.sweep_en = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_pos = 3'd0;

    // cmd 3 from reset: three right steps, done on the third
    tbl.push_back(mk( 3,0,0,0,0, 0,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 1,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 2,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 3,0,0,1,0,0,1));
    // cmd 7 clamps to 5
    tbl.push_back(mk( 7,0,0,0,0, 3,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 4,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 5,0,0,1,0,0,1));
    // manual left back to 0, then release
    tbl.push_back(mk(-1,1,0,0,0, 5,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 4,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 3,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 2,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 1,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 0,1,0,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 0,0,0,0,0,0,1));
    // seek to 5, abort by btn_l, manual down to 0 and saturate
    tbl.push_back(mk( 5,0,0,0,0, 0,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 1,0,1,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 2,0,1,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 3,1,0,0,1,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 2,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 1,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 0,1,0,0,0,1,0));
    tbl.push_back(mk(-1,1,0,0,0, 0,1,0,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 0,0,0,0,0,0,1));
    // sweep for 14 ticks, then disable
    tbl.push_back(mk(-1,0,0,1,0, 0,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 1,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 2,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 3,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 4,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 5,1,0,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 4,1,0,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 3,1,0,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 2,1,0,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 1,1,0,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 0,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 1,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 2,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,1,0, 3,0,1,0,0,1,1));
    tbl.push_back(mk(-1,0,0,0,0, 4,0,0,0,0,0,1));
    // both buttons with a command offered: nothing moves, nothing accepted
    tbl.push_back(mk(-1,1,1,0,1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(-1,1,1,0,1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(-1,0,0,0,0, 4,0,0,0,0,0,1));
    // seek toward 0, stopped at pos 2 by reset below
    tbl.push_back(mk( 0,0,0,0,0, 4,1,0,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 3,1,0,0,0,1,0));
    tbl.push_back(mk(-1,0,0,0,0, 2,1,0,0,0,1,0));

    #1;
    check("rst.pos",   8'(bus.pos),       8'd0);
    check("rst.l",     8'(bus.l_ctrl),    8'd0);
    check("rst.r",     8'(bus.r_ctrl),    8'd0);
    check("rst.done",  8'(bus.cmd_done),  8'd0);
    check("rst.abort", 8'(bus.cmd_abort), 8'd0);
    check("rst.busy",  8'(bus.busy),      8'd0);
    check("rst.ready", 8'(bus.cmd_ready), 8'd1);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].cmd >= 0) issue_cmd(tbl[i].cmd);
      run_vec(tbl[i]);
    end

    #2;
    rst = 1'b1;
    #2;
    check("midrst.pos",   8'(bus.pos),       8'd0);
    check("midrst.l",     8'(bus.l_ctrl),    8'd0);
    check("midrst.r",     8'(bus.r_ctrl),    8'd0);
    check("midrst.busy",  8'(bus.busy),      8'd0);
    check("midrst.done",  8'(bus.cmd_done),  8'd0);
    check("midrst.abort", 8'(bus.cmd_abort), 8'd0);
    check("midrst.ready", 8'(bus.cmd_ready), 8'd1);
    @(negedge clk);
    rst = 1'b0;

    issue_cmd(3);
    @(posedge clk); #1;
    check("phase.e2.r",    8'(bus.r_ctrl), 8'd0);
    @(posedge clk); #1;
    check("phase.e3.r",    8'(bus.r_ctrl), 8'd0);
    check("phase.e3.busy", 8'(bus.busy),   8'd0);
    @(posedge clk); #1;
    check("phase.e4.r",    8'(bus.r_ctrl), 8'd1);
    check("phase.e4.busy", 8'(bus.busy),   8'd1);
    check("phase.e4.pos",  8'(bus.pos),    8'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
